// File: rtl/simax_pkg.sv
// Definitions shared by the systolic-array output stages: FSM state codes and
// signed narrowing with saturation.
package simax_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] data;
    } sat_res_t;

    // v is a sign-extended accumulator; the result fits in out_w bits (out_w < SAT_W).
    function automatic sat_res_t sat_narrow(input logic signed [SAT_W-1:0] v,
                                            input int                      out_w);
        sat_res_t                r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            r.data = hi;
            r.sat  = 1'b1;
        end else if (v < lo) begin
            r.data = lo;
            r.sat  = 1'b1;
        end else begin
            r.data = v;
            r.sat  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_narrow.sv
// Combinational signed saturation of one ACC_W accumulator down to OUT_W.
module sat_narrow #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] data,
    output logic             sat
);
    simax_pkg::sat_res_t              res;
    logic signed [simax_pkg::SAT_W-1:0] acc_ext;
    logic                             unused_hi;

    assign acc_ext = simax_pkg::SAT_W'(signed'(acc));

    always_comb begin
        res = simax_pkg::sat_narrow(acc_ext, OUT_W);
    end

    assign data      = res.data[OUT_W-1:0];
    assign sat       = res.sat;
    // Upper bits are pure sign extension once saturated.
    assign unused_hi = ^res.data[simax_pkg::SAT_W-1:OUT_W];

endmodule

// File: rtl/result_drain.sv
// Snapshots the systolic array accumulators on a store_en rising edge and
// streams them row-major, saturated and addressed, over a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for a store_en rising edge to capture
// STREAM | presenting snapshot[index], advancing on each handshake
// DONE   | stream complete, waiting for store_en to drop
module result_drain
    import simax_pkg::*;
#(
    parameter int ROWS   = 2,
    parameter int COLS   = 4,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      store_en,
    input  logic [ROWS*COLS*ACC_W-1:0] acc_flat,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [ADDR_W-1:0]         out_addr,
    output logic                      out_sat,
    output logic                      out_last,
    output logic                      busy,
    output logic                      drain_done
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [1:0]         state;
    logic               store_en_q;
    logic [IDX_W-1:0]   idx;
    logic [N*ACC_W-1:0] snap;
    logic [ADDR_W-1:0]  base_q;
    logic [ACC_W-1:0]   sel_acc;
    logic [OUT_W-1:0]   sat_data;
    logic               sat_flag;
    logic               streaming;

    assign streaming = (state == ST_STREAM);
    assign sel_acc   = snap[int'(idx)*ACC_W +: ACC_W];

    sat_narrow #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
    ) u_sat (
        .acc  (sel_acc),
        .data (sat_data),
        .sat  (sat_flag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            store_en_q <= 1'b0;
            idx        <= '0;
            snap       <= '0;
            base_q     <= '0;
        end else begin
            store_en_q <= store_en;
            case (state)
                ST_IDLE: begin
                    if (store_en && !store_en_q) begin
                        snap   <= acc_flat;
                        base_q <= base_addr;
                        idx    <= '0;
                        state  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!store_en) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Word fields are forced to zero outside STREAM so idle outputs are clean.
    assign out_valid  = streaming;
    assign out_data   = streaming ? sat_data : '0;
    assign out_addr   = streaming ? (base_q + ADDR_W'(idx)) : '0;
    assign out_sat    = streaming && sat_flag;
    assign out_last   = streaming && (idx == LAST_IDX);
    assign busy       = streaming;
    assign drain_done = (state == ST_DONE);

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: stimulus pushes expected words, a negedge
// monitor pops and compares them on every handshake.
module tb_result_drain;
    localparam int ROWS = 2, COLS = 4, ACC_W = 24, OUT_W = 16, ADDR_W = 8;
    localparam int N = ROWS * COLS;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   store_en = 1'b0;
    logic [N*ACC_W-1:0]     acc_flat = '0;
    logic [ADDR_W-1:0]      base_addr = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [OUT_W-1:0]       out_data;
    logic [ADDR_W-1:0]      out_addr;
    logic                   out_sat;
    logic                   out_last;
    logic                   busy;
    logic                   drain_done;

    typedef struct {
        logic [OUT_W-1:0]  data;
        logic [ADDR_W-1:0] addr;
        logic              sat;
        logic              last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_vals[N];

    result_drain #(
        .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .store_en   (store_en),
        .acc_flat   (acc_flat),
        .base_addr  (base_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_sat    (out_sat),
        .out_last   (out_last),
        .busy       (busy),
        .drain_done (drain_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_acc();
        for (int i = 0; i < N; i++) acc_flat[i*ACC_W +: ACC_W] = ACC_W'(acc_vals[i]);
    endtask

    task automatic push_expected(input logic [ADDR_W-1:0] base);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (acc_vals[i] > 32767) begin
                e.data = 16'h7FFF; e.sat = 1'b1;
            end else if (acc_vals[i] < -32768) begin
                e.data = 16'h8000; e.sat = 1'b1;
            end else begin
                e.data = 16'(acc_vals[i]); e.sat = 1'b0;
            end
            e.addr = ADDR_W'(int'(base) + i);
            e.last = (i == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!drain_done && n < budget) begin
            tick();
            n++;
        end
        check("drain_done_reached", drain_done, 1);
    endtask

    // Monitor: compares every accepted word and checks stall stability.
    logic              was_stalled = 1'b0;
    logic [OUT_W-1:0]  held_data;
    logic [ADDR_W-1:0] held_addr;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            was_stalled = 1'b0;
        end else begin
            if (was_stalled && out_valid) begin
                check("stall_hold_data", out_data, held_data);
                check("stall_hold_addr", out_addr, held_addr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", out_data, e.data);
                    check("word_addr", out_addr, e.addr);
                    check("word_sat", out_sat, e.sat);
                    check("word_last", out_last, e.last);
                end
            end
            was_stalled = out_valid && !out_ready;
            held_data   = out_data;
            held_addr   = out_addr;
        end
    end

    initial begin
        // Reset state
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", drain_done, 0);
        check("rst_data", out_data, 0);
        rst = 1'b0;
        tick();

        // Row-major stream with exact timing
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) acc_vals[r*COLS+c] = r*10 + c;
        load_acc();
        base_addr = 8'h20;
        out_ready = 1'b1;
        push_expected(8'h20);
        store_en = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            check("t1_valid", out_valid, 1);
            check("t1_busy", busy, 1);
            check("t1_last_only_final", out_last, (i == N - 1) ? 1 : 0);
            check("t1_done_early", drain_done, 0);
            tick();
        end
        check("t1_done_at_e9", drain_done, 1);
        check("t1_valid_in_done", out_valid, 0);
        tick();
        check("t1_done_held_while_store", drain_done, 1);
        store_en = 1'b0;
        tick();
        check("t1_back_idle", drain_done, 0);
        check("t1_queue_empty", exp_q.size(), 0);

        // Saturation
        acc_vals = '{40000, -40000, 32767, -32768, 5, -5, 8388607, -8388608};
        load_acc();
        base_addr = 8'h00;
        push_expected(8'h00);
        store_en = 1'b1;
        tick();
        wait_done(20);
        store_en = 1'b0;
        tick();
        check("t2_queue_empty", exp_q.size(), 0);

        // Backpressure 1,0,0,1,...
        acc_vals = '{100, -200, 300, -400, 500, -600, 700, -800};
        load_acc();
        base_addr = 8'h40;
        push_expected(8'h40);
        store_en = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 100 && !drain_done; k++) begin
            out_ready = ((k % 3) == 0);
            tick();
        end
        check("t3_done", drain_done, 1);
        out_ready = 1'b1;
        store_en = 1'b0;
        tick();
        check("t3_queue_empty", exp_q.size(), 0);

        // Snapshot isolation and stray store_en edges
        acc_vals = '{7, 6, 5, 4, 3, 2, 1, 0};
        load_acc();
        base_addr = 8'h80;
        push_expected(8'h80);
        store_en = 1'b1;
        tick();
        for (int k = 0; k < 20 && !drain_done; k++) begin
            acc_flat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            store_en = !(k == 2 || k == 3);
            tick();
        end
        check("t4_done", drain_done, 1);
        store_en = 1'b0;
        tick();
        check("t4_idle", drain_done, 0);
        check("t4_queue_empty", exp_q.size(), 0);

        // Address wrap, then reset mid-stream
        acc_vals = '{-1, 2, -3, 4, -5, 6, -7, 8};
        load_acc();
        base_addr = 8'hFE;
        push_expected(8'hFE);
        store_en = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("t5_word3_addr", out_addr, 8'h01);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_last", out_last, 0);
        check("t5_rst_busy", busy, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        push_expected(8'hFE);
        tick();
        check("t5_recapture_valid", out_valid, 1);
        check("t5_recapture_addr", out_addr, 8'hFE);
        wait_done(20);
        store_en = 1'b0;
        tick();
        check("t5_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
